frogger_game_ctrl: RTL and testbench
====================================

# frogger_game_ctrl

Game sequencer for the Frogger datapath. It turns raw active-low push-buttons into debounced single-cycle move pulses and generates the car-shift tick at a level-dependent rate. It runs the game state machine: idle, play, death, win and game over, including lives, score and level. It sits between the board inputs and the frogger datapath and VGA writer; the datapath applies the moves and shifts and reports collisions back.

## Interface
Parameters:
- TICK_BASE, 100_000_000: clk cycles per car shift at level 0; must be ≥ 8.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable-low cycles before a press registers.
- LIVES, 3: lives loaded at game start, range 1..3.
- HOLD_TICKS, 2: tick periods spent frozen in DYING/WIN.

Ports (`clk` is the single clock; `reset` is asynchronous, active-low):
- clk  in  1  system clock.
- reset  in  1  async active-low reset.
- up, down, left, right  in  1 each  raw buttons, active-low.
- start  in  1  raw button, active-low.
- hit  in  1  datapath collision: frog cell overlaps a car this cycle.
- frog_row  in  3  frog vertical row, 0 = goal, 7 = start.
- move_up, move_down, move_left, move_right  out  1 each  one-cycle move pulses.
- shift_tick  out  1  one-cycle pulse: datapath rotates all car rows.
- respawn  out  1  one-cycle pulse: datapath puts frog at row 7, column 8'b0001_0000.
- freeze  out  1  high outside PLAY.
- level  out  2  current level 0..3.
- lives  out  2  remaining lives.
- score  out  8  completed crossings.
- state  out  3  FSM state, for display.

## Operation
- Each button is double-flop synchronized and then debounced. A press event fires once, on the cycle the synchronized level has been low for DEBOUNCE_CYCLES consecutive cycles. It re-arms only after the synchronized level is seen high. Holding a button gives exactly one event.
- Move arbitration: at most one move pulse per cycle, with priority up > down > right > left. Losing events in the same cycle are discarded. Moves are emitted only in PLAY, excluding the respawn cycle.
- Tick period is TICK_BASE >> level. The tick counter counts 0..period-1 and clears on every entry to PLAY. shift_tick is high on the period-1 count, in PLAY only.
- FSM states:
  - IDLE: start event → PLAY; loads lives=LIVES, score=0, level=0.
  - PLAY:
    - hit → DYING, with lives decremented on entry.
    - Otherwise frog_row==0 → WIN.
    - hit and frog_row==0 in the same cycle → DYING.
    - hit is ignored in the first PLAY cycle.
  - DYING: frozen for HOLD_TICKS period expiries, with no shift_tick output. Then lives==0 → GAME_OVER; otherwise → PLAY.
  - WIN: on entry, score increments (saturating at 255) and level increments (saturating at 3). Frozen for HOLD_TICKS, then → PLAY.
  - GAME_OVER: frozen; score and level hold. A start event → PLAY with the same reload as from IDLE.
- respawn is high exactly in the first cycle of every PLAY visit.
- start events outside IDLE/GAME_OVER are ignored.

## Timing
- Reset values: state=IDLE, freeze=1, all pulses 0, level=0, lives=0, score=0. Debouncers and counters are cleared.
- Reset asserted mid-operation forces all of the above asynchronously. The first state transition occurs no earlier than the second clk edge after deassertion.
- Button latency: a raw low sampled at edge N gives the event pulse at edge N+2+DEBOUNCE_CYCLES. The move pulse is registered in that same cycle.
- State transitions occur one cycle after the triggering input is sampled.
- lives, score and level update on the same edge as the state change.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package frogger_pkg: state encoding (IDLE=0, PLAY=1, DYING=2, WIN=3, GAME_OVER=4), START_ROW=7, START_COL=8'b0001_0000, MAX_LEVEL=3. The frogger datapath shares the START_* constants.
- Sub-module button_debounce (sync + counter + edge event), instantiated five times.

## Test plan
- TICK_BASE=16, DEBOUNCE_CYCLES=4. After reset, hold start low for 10 cycles → one respawn pulse, state=PLAY, lives=3, level=0, score=0, freeze=0.
- In PLAY at level 0 → shift_tick every 16 cycles. Drive frog_row=0 and wait for the hold to end → score=1, level=1, then shift_tick every 8 cycles.
- Hold up low for 100 cycles → exactly one move_up. Press up and left together → move_up only. Press any button in DYING → no move pulse.
- Assert hit in three separate PLAY visits → lives goes 2, 1, 0. The third hit ends in GAME_OVER with freeze=1 and no shift_tick. A start event then gives lives=3 and score=0.
- Assert frog_row=0 and hit in the same cycle → DYING, score unchanged, lives decremented. Assert hit in the respawn cycle → ignored.
- Assert reset low during the WIN hold → state=IDLE, score=0, freeze=1 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared encodings and constants for the Frogger game controller and datapath.
package frogger_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPlay     = 3'd1,
        StDying    = 3'd2,
        StWin      = 3'd3,
        StGameOver = 3'd4
    } state_e;

    localparam logic [2:0] START_ROW = 3'd7;
    localparam logic [7:0] START_COL = 8'b0001_0000;
    localparam logic [1:0] MAX_LEVEL = 2'd3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stable-low counter; emits one press event per hold.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            armed_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

    // press_o is consumed by registers in the parent, so the event lands on
    // the edge at which the count reaches DEBOUNCE_CYCLES.
    always_comb begin
        press_o = 1'b0;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        if (sync2_q) begin
            armed_d = 1'b1;
            cnt_d   = '0;
        end else if (armed_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                press_o = 1'b1;
                armed_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: debounced moves, level-scaled car tick, and the
// idle/play/dying/win/game-over state machine with lives, score and level.
module frogger_game_ctrl
    import frogger_pkg::*;
#(
    parameter int unsigned TICK_BASE       = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LIVES           = 3,
    parameter int unsigned HOLD_TICKS      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       start,
    input  logic       hit,
    input  logic [2:0] frog_row,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic       shift_tick,
    output logic       respawn,
    output logic       freeze,
    output logic [1:0] level,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic [2:0] state
);

    localparam int unsigned TW = $clog2(TICK_BASE);
    localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    logic ev_up, ev_down, ev_left, ev_right, ev_start;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .reset(reset), .btn_n_i(up), .press_o(ev_up)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .reset(reset), .btn_n_i(down), .press_o(ev_down)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .reset(reset), .btn_n_i(left), .press_o(ev_left)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .reset(reset), .btn_n_i(right), .press_o(ev_right)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk(clk), .reset(reset), .btn_n_i(start), .press_o(ev_start)
    );

    state_e        state_q, state_d;
    logic [1:0]    lives_q, lives_d;
    logic [1:0]    level_q, level_d;
    logic [7:0]    score_q, score_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          respawn_q, respawn_d;
    logic [3:0]    move_q, move_d;   // {up, down, right, left}
    logic [TW-1:0] period_m1;
    logic          expire;

    assign period_m1 = TW'((TICK_BASE >> level_q) - 1);
    assign expire    = (tick_cnt_q == period_m1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            lives_q    <= '0;
            level_q    <= '0;
            score_q    <= '0;
            tick_cnt_q <= '0;
            hold_cnt_q <= '0;
            respawn_q  <= 1'b0;
            move_q     <= '0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            score_q    <= score_d;
            tick_cnt_q <= tick_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            respawn_q  <= respawn_d;
            move_q     <= move_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        score_d    = score_q;
        hold_cnt_d = hold_cnt_q;
        move_d     = '0;

        case (state_q)
            StIdle, StGameOver: begin
                if (ev_start) begin
                    state_d = StPlay;
                    lives_d = 2'(LIVES);
                    score_d = '0;
                    level_d = '0;
                end
            end
            StPlay: begin
                // Inputs in the respawn cycle still describe the old frog position.
                if (!respawn_q) begin
                    if (hit) begin
                        state_d = StDying;
                        lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    end else if (frog_row == 3'd0) begin
                        state_d = StWin;
                        score_d = sat_inc8(score_q);
                        level_d = (level_q == MAX_LEVEL) ? level_q : level_q + 2'd1;
                    end
                end
            end
            StDying, StWin: begin
                if (expire) begin
                    if (hold_cnt_q == HW'(HOLD_TICKS - 1)) begin
                        state_d = (state_q == StDying && lives_q == 2'd0) ? StGameOver
                                                                          : StPlay;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            hold_cnt_d = '0;
        end
        tick_cnt_d = (state_d != state_q || expire) ? '0 : tick_cnt_q + TW'(1);
        respawn_d  = (state_d == StPlay) && (state_q != StPlay);

        if (state_q == StPlay && !respawn_q) begin
            if (ev_up)         move_d = 4'b1000;
            else if (ev_down)  move_d = 4'b0100;
            else if (ev_right) move_d = 4'b0010;
            else if (ev_left)  move_d = 4'b0001;
        end
    end

    assign move_up    = move_q[3];
    assign move_down  = move_q[2];
    assign move_right = move_q[1];
    assign move_left  = move_q[0];
    assign respawn    = respawn_q;
    assign shift_tick = (state_q == StPlay) && expire;
    assign freeze     = (state_q != StPlay);
    assign level      = level_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign state      = state_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Scoreboard bench: stimulus queues expected pulses; a monitor pops and checks them.
module tb_frogger_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn_n;   // {start, up, down, right, left}, active-low
    logic       hit;
    logic [2:0] frog_row;
    logic       move_up, move_down, move_left, move_right;
    logic       shift_tick, respawn, freeze;
    logic [1:0] level, lives;
    logic [7:0] score;
    logic [2:0] state;

    frogger_game_ctrl #(
        .TICK_BASE(16), .DEBOUNCE_CYCLES(4), .LIVES(3), .HOLD_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset),
        .up(btn_n[3]), .down(btn_n[2]), .left(btn_n[0]), .right(btn_n[1]),
        .start(btn_n[4]), .hit(hit), .frog_row(frog_row),
        .move_up(move_up), .move_down(move_down), .move_left(move_left),
        .move_right(move_right), .shift_tick(shift_tick), .respawn(respawn),
        .freeze(freeze), .level(level), .lives(lives), .score(score), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] K_RSP = 5'b10000;
    localparam logic [4:0] K_UP  = 5'b01000;
    localparam logic [4:0] K_DN  = 5'b00100;
    localparam logic [4:0] K_RT  = 5'b00010;
    localparam logic [4:0] K_LT  = 5'b00001;

    localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_WIN = 3, S_GO = 4;

    typedef struct packed {
        logic [4:0] kind;
        logic [1:0] lives;
        logic [7:0] score;
        logic [1:0] level;
    } ev_t;

    typedef struct {
        int visit;
        int gap;
    } tick_t;

    ev_t   ev_q[$];
    tick_t tick_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_ticks  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] mask, input int n);
        btn_n = ~mask;
        cyc(n);
        btn_n = 5'b11111;
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        int k = 0;
        while (int'(state) != target && k < budget) begin
            cyc(1);
            k++;
        end
        check(name, int'(state), target);
    endtask

    task automatic push_ev(input logic [4:0] k, input int l, input int s, input int v);
        ev_q.push_back({k, 2'(l), 8'(s), 2'(v)});
    endtask

    task automatic push_tick(input int visit, input int gap);
        tick_q.push_back('{visit, gap});
    endtask

    // Monitor: every pulse must match the head of the queue; ticks check spacing.
    initial begin
        logic [4:0] kind;
        ev_t        e, got;
        tick_t      t;
        int         visit;
        int         since;
        visit = 0;
        since = 0;
        forever begin
            @(negedge clk);
            since++;
            kind = {respawn, move_up, move_down, move_right, move_left};
            if (kind != 5'b0) begin
                n_checks++;
                if (ev_q.size() == 0) begin
                    $display("FAIL unexpected_pulse: got kind %b, expected no pulse", kind);
                end else begin
                    e   = ev_q.pop_front();
                    got = {kind, lives, score, level};
                    if (got == e) n_pass++;
                    else $display("FAIL pulse: got %b/l%0d/s%0d/v%0d, expected %b/l%0d/s%0d/v%0d",
                                  got.kind, got.lives, got.score, got.level,
                                  e.kind, e.lives, e.score, e.level);
                end
            end
            if (respawn) begin
                visit++;
                since = 0;
            end
            if (shift_tick) begin
                n_ticks++;
                check("tick_in_play", int'(freeze), 0);
                if (tick_q.size() > 0 && tick_q[0].visit == visit) begin
                    t = tick_q.pop_front();
                    check("tick_gap", since, t.gap);
                end
                since = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        btn_n    = 5'b11111;
        hit      = 1'b0;
        frog_row = 3'd7;
        reset    = 1'b0;
        cyc(3);
        check("rst_state", int'(state), S_IDLE);
        check("rst_freeze", int'(freeze), 1);
        check("rst_lives", int'(lives), 0);
        check("rst_score", int'(score), 0);
        check("rst_level", int'(level), 0);
        check("rst_pulses", int'({respawn, move_up, move_down, move_right, move_left,
                                  shift_tick}), 0);
        reset = 1'b1;
        cyc(2);

        // Start game; level 0 ticks every 16 cycles.
        push_ev(K_RSP, 3, 0, 0);
        push_tick(1, 15);
        push_tick(1, 16);
        push_tick(1, 16);
        press(K_RSP, 10);
        wait_state(S_PLAY, 20, "start_to_play");
        check("play_lives", int'(lives), 3);
        check("play_score", int'(score), 0);
        check("play_level", int'(level), 0);
        check("play_freeze", int'(freeze), 0);
        cyc(50);
        check("ticks_l0_seen", tick_q.size(), 0);

        // Crossing: score and level step, then ticks every 8 cycles.
        push_ev(K_RSP, 3, 1, 1);
        push_tick(2, 7);
        push_tick(2, 8);
        push_tick(2, 8);
        frog_row = 3'd0;
        cyc(1);
        frog_row = 3'd7;
        wait_state(S_WIN, 5, "state_win");
        check("win_score", int'(score), 1);
        check("win_level", int'(level), 1);
        check("win_freeze", int'(freeze), 1);
        wait_state(S_PLAY, 40, "win_to_play");
        cyc(30);
        check("ticks_l1_seen", tick_q.size(), 0);

        // Moves: long hold gives one pulse; simultaneous presses obey priority.
        push_ev(K_UP, 3, 1, 1);
        press(K_UP, 100);
        cyc(5);
        push_ev(K_UP, 3, 1, 1);
        press(K_UP | K_LT, 10);
        cyc(5);
        push_ev(K_RT, 3, 1, 1);
        press(K_RT | K_LT, 10);
        cyc(5);
        push_ev(K_DN, 3, 1, 1);
        press(K_DN | K_RT, 10);
        cyc(5);
        check("moves_seen", ev_q.size(), 0);

        // First hit; a press while dying must not move.
        push_ev(K_RSP, 2, 1, 1);
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        wait_state(S_DYING, 5, "state_dying_1");
        check("lives_after_hit1", int'(lives), 2);
        press(K_DN, 10);
        wait_state(S_PLAY, 40, "dying_to_play_1");
        // Hit during the respawn cycle is ignored.
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        cyc(3);
        check("respawn_hit_ignored", int'(state), S_PLAY);
        check("respawn_hit_lives", int'(lives), 2);

        push_ev(K_RSP, 1, 1, 1);
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        wait_state(S_DYING, 5, "state_dying_2");
        check("lives_after_hit2", int'(lives), 1);
        wait_state(S_PLAY, 40, "dying_to_play_2");
        cyc(3);

        // Hit and goal together: dying wins, score unchanged.
        frog_row = 3'd0;
        hit      = 1'b1;
        cyc(1);
        frog_row = 3'd7;
        hit      = 1'b0;
        wait_state(S_DYING, 5, "state_dying_3");
        check("lives_after_hit3", int'(lives), 0);
        check("score_after_hit3", int'(score), 1);
        wait_state(S_GO, 40, "state_game_over");
        check("go_freeze", int'(freeze), 1);
        check("go_score", int'(score), 1);
        check("go_level", int'(level), 1);
        t0 = n_ticks;
        cyc(40);
        check("go_no_tick", n_ticks - t0, 0);
        check("go_holds", int'(state), S_GO);

        // Restart from game over reloads.
        push_ev(K_RSP, 3, 0, 0);
        push_tick(5, 15);
        push_tick(5, 16);
        press(K_RSP, 10);
        wait_state(S_PLAY, 20, "restart_play");
        check("restart_lives", int'(lives), 3);
        check("restart_score", int'(score), 0);
        check("restart_level", int'(level), 0);
        cyc(40);
        check("ticks_restart_seen", tick_q.size(), 0);

        // Asynchronous reset in the middle of the win hold.
        frog_row = 3'd0;
        cyc(1);
        frog_row = 3'd7;
        wait_state(S_WIN, 5, "state_win_2");
        check("win2_score", int'(score), 1);
        cyc(3);
        #2 reset = 1'b0;
        #1;
        check("async_rst_state", int'(state), S_IDLE);
        check("async_rst_score", int'(score), 0);
        check("async_rst_freeze", int'(freeze), 1);
        check("async_rst_level", int'(level), 0);
        check("async_rst_lives", int'(lives), 0);
        cyc(2);
        reset = 1'b1;
        cyc(4);
        check("idle_after_reset", int'(state), S_IDLE);
        check("events_all_seen", ev_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
